// File: rtl/lemon_ifu.sv
// LemonPC instruction-fetch unit: credit-limited sequential fetcher with an
// in-order response FIFO, redirect squash and sticky halt.
module lemon_ifu #(
    parameter int                XLEN    = 64,
    parameter int                INST_W  = 32,
    parameter logic [XLEN-1:0]   PC_INIT = 64'h8000_0000,
    parameter int                DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              halted
);

    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam int              PW   = $clog2(DEPTH);
    localparam logic [XLEN-1:0] STEP = XLEN'(INST_W / 8);

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   head_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     fifo_count;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              halt_flag;
    logic [INST_W-1:0] fifo_mem [DEPTH];

    logic [CW:0]       credit_used;
    logic [CW-1:0]     outstanding_next;
    logic              can_issue;
    logic              req_hs;
    logic              resp_push;
    logic              pop;

    // Every issued request owns a FIFO slot until it is popped or dropped,
    // so a non-dropped response always finds room.
    assign credit_used      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign can_issue        = !halt_flag && (credit_used < (CW+1)'(DEPTH));
    assign outstanding_next = outstanding + CW'(req_hs) - CW'(imem_resp_valid);

    assign imem_req_valid = rst_n && can_issue;
    assign imem_req_addr  = rst_n ? fetch_pc : PC_INIT;
    assign inst_valid     = rst_n && (fifo_count != '0);
    assign inst           = rst_n ? fifo_mem[rd_ptr] : '0;
    assign inst_pc        = rst_n ? head_pc : '0;
    assign halted         = rst_n && halt_flag && (outstanding == '0);

    assign req_hs    = imem_req_valid && imem_req_ready;
    assign resp_push = imem_resp_valid && (drop_cnt == '0);
    assign pop       = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= PC_INIT;
            head_pc     <= PC_INIT;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            halt_flag   <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            halt_flag   <= halt_flag | halt;
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old path.
                fetch_pc   <= redirect_pc;
                head_pc    <= redirect_pc;
                drop_cnt   <= outstanding_next;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (req_hs)
                    fetch_pc <= fetch_pc + STEP;
                if (imem_resp_valid && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (resp_push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop) begin
                    rd_ptr  <= rd_ptr + PW'(1);
                    head_pc <= head_pc + STEP;
                end
                fifo_count <= fifo_count + CW'(resp_push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resp_push)
            fifo_mem[wr_ptr] <= imem_resp_data;
    end

    resp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_resp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_lemon_ifu.sv
// Bench for lemon_ifu: in-order memory model, {inst, pc} scoreboard and a
// cycle table for the fill/backpressure sequence.
`timescale 1ns/1ps
module tb_lemon_ifu;

    localparam logic [63:0] PC_INIT = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        halted;

    lemon_ifu #(.XLEN(64), .INST_W(32), .PC_INIT(PC_INIT), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [63:0] pc; } exp_t;
    typedef struct { logic [63:0] addr; int due; } mreq_t;
    typedef struct { logic ir; logic rv; logic [63:0] addr; logic iv; logic [63:0] pc; } vec_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    logic mem_hold = 1'b0;
    logic halt_m = 1'b0;
    int m_out = 0;
    int n_req = 0;
    int pops = 0;
    logic [63:0] model_pc = PC_INIT;
    logic [63:0] last_pop_pc = '0;
    logic s_rv, s_iv, s_hs, s_pop, s_halted;
    logic [63:0] s_addr, s_pc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic checkb(input string name, input logic got, input logic want);
        check(name, 64'(got), 64'(want));
    endtask

    task automatic checki(input string name, input int got, input int want);
        check(name, 64'(got), 64'(want));
    endtask

    // One clock: sample at negedge+1, update models, then present next response.
    task automatic cycle();
        exp_t e;
        #1;
        s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = inst_valid;
        s_pc = inst_pc; s_halted = halted;
        s_hs = s_rv && imem_req_ready;
        s_pop = s_iv && inst_ready;
        if (!rst_n) begin
            checkb("rst_req_valid", s_rv, 1'b0);
            check("rst_req_addr", s_addr, PC_INIT);
            checkb("rst_inst_valid", s_iv, 1'b0);
            check("rst_inst", 64'(inst), 64'd0);
            check("rst_inst_pc", s_pc, 64'd0);
            checkb("rst_halted", s_halted, 1'b0);
            exp_q.delete(); mem_q.delete();
            model_pc = PC_INIT; halt_m = 1'b0; m_out = 0;
        end else begin
            checkb("halted", s_halted, halt_m && (m_out == 0));
            if (halt_m && s_rv) begin
                checks++; errors++;
                $display("FAIL req_after_halt: req_valid=1 expected 0");
            end
            if (s_pop) begin
                pops++;
                last_pop_pc = s_pc;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop_unexpected: pc %h with no expected entry", s_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_inst_pc", s_pc, e.pc);
                    check("sb_inst", 64'(inst), 64'(e.data));
                end
            end
            if (s_hs) begin
                check("req_addr", s_addr, model_pc);
                mem_q.push_back('{addr: s_addr, due: cyc + mem_lat});
                m_out++; n_req++;
            end
            if (imem_resp_valid) m_out--;
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = redirect_pc;
            end else if (s_hs) begin
                exp_q.push_back('{data: mem_word(model_pc), pc: model_pc});
                model_pc = model_pc + 64'd4;
            end
            if (halt) halt_m = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect_valid = 1'b0;
        halt = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        if (rst_n && !mem_hold && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_first_pop(input string name, input logic [63:0] want);
        int start;
        start = pops;
        for (int i = 0; i < 30 && pops == start; i++) cycle();
        if (pops == start) begin
            checks++; errors++;
            $display("FAIL %s: no instruction delivered within 30 cycles", name);
        end else begin
            check(name, last_pop_pc, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        int n0, p0;
        tbl[0]  = '{ir: 1'b1, rv: 1'b1, addr: 64'h8000_0000, iv: 1'b0, pc: 64'h0};
        tbl[1]  = '{ir: 1'b1, rv: 1'b1, addr: 64'h8000_0004, iv: 1'b0, pc: 64'h0};
        tbl[2]  = '{ir: 1'b1, rv: 1'b1, addr: 64'h8000_0008, iv: 1'b1, pc: 64'h8000_0000};
        tbl[3]  = '{ir: 1'b0, rv: 1'b1, addr: 64'h8000_000C, iv: 1'b1, pc: 64'h8000_0004};
        tbl[4]  = '{ir: 1'b0, rv: 1'b1, addr: 64'h8000_0010, iv: 1'b1, pc: 64'h8000_0004};
        tbl[5]  = '{ir: 1'b0, rv: 1'b0, addr: 64'h0,         iv: 1'b1, pc: 64'h8000_0004};
        tbl[6]  = '{ir: 1'b0, rv: 1'b0, addr: 64'h0,         iv: 1'b1, pc: 64'h8000_0004};
        tbl[7]  = '{ir: 1'b1, rv: 1'b0, addr: 64'h0,         iv: 1'b1, pc: 64'h8000_0004};
        tbl[8]  = '{ir: 1'b0, rv: 1'b1, addr: 64'h8000_0014, iv: 1'b1, pc: 64'h8000_0008};
        tbl[9]  = '{ir: 1'b0, rv: 1'b0, addr: 64'h0,         iv: 1'b1, pc: 64'h8000_0008};
        tbl[10] = '{ir: 1'b0, rv: 1'b0, addr: 64'h0,         iv: 1'b1, pc: 64'h8000_0008};

        // Sequential fetch with 1-cycle memory, then backpressure and refill.
        mem_lat = 1; mem_hold = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            inst_ready = tbl[i].ir;
            cycle();
            checkb("tbl_req_valid", s_rv, tbl[i].rv);
            if (tbl[i].rv) check("tbl_req_addr", s_addr, tbl[i].addr);
            checkb("tbl_inst_valid", s_iv, tbl[i].iv);
            if (tbl[i].iv) check("tbl_inst_pc", s_pc, tbl[i].pc);
        end

        // Credit limit from reset with decode stalled.
        inst_ready = 1'b0;
        do_reset();
        n0 = n_req;
        repeat (10) cycle();
        checki("t2_req_count", n_req - n0, 4);
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        n0 = n_req;
        cycle();
        checkb("t2_refill_rv", s_rv, 1'b1);
        repeat (4) cycle();
        checki("t2_refill_count", n_req - n0, 1);

        // Redirect with two in flight and a same-cycle pop.
        do_reset();
        cycle();
        mem_hold = 1'b1;
        cycle();
        cycle();
        imem_req_ready = 1'b0; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        cycle();
        checkb("t3_head_at_redirect", s_iv, 1'b1);
        imem_req_ready = 1'b1; mem_hold = 1'b0;
        cycle();
        checkb("t3_iv_after_redirect", s_iv, 1'b0);
        wait_first_pop("t3_first_pc", 64'h8000_1000);

        // Redirect coinciding with a request handshake and a response.
        mem_lat = 2; inst_ready = 1'b1;
        do_reset();
        cycle();
        cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        cycle();
        checkb("t4_same_cycle_hs", s_hs, 1'b1);
        cycle();
        checkb("t4_iv_after_redirect", s_iv, 1'b0);
        wait_first_pop("t4_first_pc", 64'h8000_2000);

        // PC wrap across the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        cycle();
        wait_first_pop("wrap_first_pc", 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (3) cycle();
        check("wrap_later_pc", last_pop_pc, 64'h0000_0000_0000_0004);

        // Halt with three requests in flight.
        mem_lat = 1; mem_hold = 1'b1;
        do_reset();
        cycle();
        cycle();
        halt = 1'b1;
        cycle();
        checkb("t5_hs_with_halt", s_hs, 1'b1);
        mem_hold = 1'b0;
        n0 = n_req; p0 = pops;
        cycle();
        checkb("t5_rv_after_halt", s_rv, 1'b0);
        checkb("t5_halted_busy", s_halted, 1'b0);
        repeat (12) cycle();
        checki("t5_new_reqs", n_req - n0, 0);
        checki("t5_pops", pops - p0, 3);
        checkb("t5_halted", s_halted, 1'b1);

        // Reset while the FIFO is full.
        inst_ready = 1'b0;
        do_reset();
        repeat (8) cycle();
        checkb("t6_full_iv", s_iv, 1'b1);
        checkb("t6_full_rv", s_rv, 1'b0);
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        checkb("t6_first_rv", s_rv, 1'b1);
        check("t6_first_addr", s_addr, PC_INIT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
